// File: rtl/reg8_a.sv
// 8-bit parallel-load register with load enable and asynchronous clear.
// Each bit cell is a gate-level 2:1 recirculating select feeding a clear-able rising-edge flop.
module reg8_a (
  input  logic       Clk,
  input  logic       Res,
  input  logic       En,
  input  logic [7:0] reg_in,
  output logic [7:0] reg_out
);

  logic       en_n;
  logic [7:0] sel_load;
  logic [7:0] sel_hold;
  logic [7:0] d;
  logic [7:0] q;

  assign en_n = ~En;

  for (genvar i = 0; i < 8; i++) begin : g_cell
    // AND-OR select: En picks reg_in, otherwise the cell recirculates its own Q.
    assign sel_load[i] = reg_in[i] & En;
    assign sel_hold[i] = q[i] & en_n;
    assign d[i]        = sel_load[i] | sel_hold[i];

    always_ff @(posedge Clk or posedge Res) begin
      if (Res) begin
        q[i] <= 1'b0;
      end else begin
        q[i] <= d[i];
      end
    end
  end

  assign reg_out = q;

endmodule

// File: tb/tb_reg8_a.sv
// Self-checking bench for reg8_a: directed vector table, async-clear corner cases and
// a randomized lockstep run against a simple golden register model.
module tb_reg8_a;

  logic       clk;
  logic       res;
  logic       en;
  logic [7:0] din;
  logic [7:0] dout;

  int checks;
  int failures;

  // Golden model state: async clear to zero, enabled rising-edge load.
  logic [7:0] model;

  reg8_a dut (
    .Clk    (clk),
    .Res    (res),
    .En     (en),
    .reg_in (din),
    .reg_out(dout)
  );

  initial clk = 1'b0;
  always #8 clk = ~clk;

  typedef struct {
    string      name;
    logic       res;
    logic       en;
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, got, exp, $time);
    end
  endtask

  // Drive inputs mid-cycle, check 2 ns after that toggle and 2 ns after the next rising edge.
  task automatic step(input string name, input logic r, input logic e, input logic [7:0] d);
    @(negedge clk);
    res = r;
    en  = e;
    din = d;
    if (r) model = 8'h00;
    #2;
    check({name, "_mid"}, dout, model);
    @(posedge clk);
    if (!r && e) model = d;
    #2;
    check({name, "_edge"}, dout, model);
  endtask

  vec_t vecs[$];

  initial begin
    checks   = 0;
    failures = 0;
    model    = 8'hxx;
    res      = 1'b0;
    en       = 1'b0;
    din      = 8'h00;

    vecs.push_back('{"load_a5",  1'b0, 1'b1, 8'hA5, 8'hA5});
    vecs.push_back('{"hold0",    1'b0, 1'b0, 8'h3C, 8'hA5});
    vecs.push_back('{"hold1",    1'b0, 1'b0, 8'h3C, 8'hA5});
    vecs.push_back('{"hold2",    1'b0, 1'b0, 8'h3C, 8'hA5});
    vecs.push_back('{"hold3",    1'b0, 1'b0, 8'h3C, 8'hA5});
    vecs.push_back('{"b2b_ff",   1'b0, 1'b1, 8'hFF, 8'hFF});
    vecs.push_back('{"b2b_00",   1'b0, 1'b1, 8'h00, 8'h00});
    vecs.push_back('{"b2b_55",   1'b0, 1'b1, 8'h55, 8'h55});
    vecs.push_back('{"b2b_aa",   1'b0, 1'b1, 8'hAA, 8'hAA});

    // Reset with no clock edge: clear must be immediate.
    #3;
    res   = 1'b1;
    model = 8'h00;
    #2;
    check("reset_async", dout, 8'h00);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #2;
      check("reset_hold", dout, 8'h00);
    end

    // Enable asserted while reset is held.
    @(negedge clk);
    en  = 1'b1;
    din = 8'h77;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #2;
      check("en_under_reset", dout, 8'h00);
      check("en_under_reset_model", dout, model);
    end

    // Directed table: load, hold, back-to-back loads.
    foreach (vecs[i]) begin
      @(negedge clk);
      res = vecs[i].res;
      en  = vecs[i].en;
      din = vecs[i].din;
      @(posedge clk);
      #2;
      check(vecs[i].name, dout, vecs[i].exp);
    end
    model = 8'hAA;

    // Async clear pulse of 3 ns between edges with 0xFF held.
    step("preload_ff", 1'b0, 1'b1, 8'hFF);
    #1;
    res   = 1'b1;
    model = 8'h00;
    #2;
    check("pulse_clear", dout, 8'h00);
    #1;
    res = 1'b0;
    #1;
    check("pulse_release", dout, 8'h00);
    step("post_clear_hold", 1'b0, 1'b0, 8'hC3);
    step("post_clear_load", 1'b0, 1'b1, 8'h5A);

    // Reset with clock edge and enable: reset wins.
    step("reset_wins", 1'b1, 1'b1, 8'hE7);
    step("release_load", 1'b0, 1'b1, 8'h81);

    // Randomized lockstep against the model, sampled after each clock toggle.
    for (int i = 0; i < 48; i++) begin
      step("rand", ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
